// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter in front of a single-port synchronous data memory.
// Port 0 (processor) and port 1 (loader/debug) compete for the memory. Grants are
// registered state bits. Ties from IDLE go to the port that did not own last.
// A tenure is capped at MAX_BURST accesses while the other port is waiting.
// Read data returns one cycle after issue on the port that issued the read.
module dm_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        sysclk,
  input  logic        rst,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [6:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [6:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,

  output logic        DMclka,
  output logic        DMena,
  output logic        DMwea,
  output logic [6:0]  DMaddra,
  output logic [31:0] DMdina,
  input  logic [31:0] DMdouta
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Count value at which the owner has issued its MAX_BURST-th access.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t      state;
  state_t      state_nxt;
  state_t      other_state;
  logic        last_owner;      // 0: port 0 owned last, 1: port 1 owned last
  logic        last_owner_nxt;
  logic [3:0]  burst_cnt;
  logic [3:0]  burst_cnt_nxt;
  logic        rvalid0_q;
  logic        rvalid1_q;

  logic        own_req;
  logic        own_we;
  logic        other_req;
  logic [6:0]  own_addr;
  logic [31:0] own_wdata;
  logic        issue;

  // Route the current owner's request onto a common set of signals.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves a
    // signal unassigned would otherwise infer a latch.
    own_req     = 1'b0;
    own_we      = 1'b0;
    other_req   = 1'b0;
    own_addr    = '0;
    own_wdata   = '0;
    other_state = IDLE;
    unique case (state)
      OWN0: begin
        own_req     = p0_req;
        own_we      = p0_we;
        other_req   = p1_req;
        own_addr    = p0_addr;
        own_wdata   = p0_wdata;
        other_state = OWN1;
      end
      OWN1: begin
        own_req     = p1_req;
        own_we      = p1_we;
        other_req   = p0_req;
        own_addr    = p1_addr;
        own_wdata   = p1_wdata;
        other_state = OWN0;
      end
      default: ;
    endcase
  end

  // An access goes out when the owner is requesting; nothing issues while reset
  // is being applied so a mid-tenure reset cannot leak a write into the memory.
  assign issue = rst & own_req;

  // Next-state, burst counting and tie-break bookkeeping.
  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    unique case (state)
      IDLE: begin
        if (p0_req && (!p1_req || last_owner)) begin
          state_nxt = OWN0;
        end else if (p1_req) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          // Owner released: hand straight over if the other port waits.
          state_nxt = other_req ? other_state : IDLE;
        end else if (burst_cnt == BURST_LAST) begin
          // Burst limit reached on this access: yield only if someone waits,
          // otherwise keep the memory and start a fresh burst window.
          if (other_req) begin
            state_nxt = other_state;
          end else begin
            burst_cnt_nxt = '0;
          end
        end else begin
          burst_cnt_nxt = burst_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Any change of state starts a new tenure.
    if (state_nxt != state) begin
      burst_cnt_nxt = '0;
      if (state_nxt == OWN0) begin
        last_owner_nxt = 1'b0;
      end else if (state_nxt == OWN1) begin
        last_owner_nxt = 1'b1;
      end
    end
  end

  // State, counters and read-return flags, cleared by synchronous reset.
  always_ff @(posedge sysclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      // The read's port is captured at issue, so it returns to the issuer even
      // when ownership changes on the same edge.
      rvalid0_q  <= issue & ~own_we & (state == OWN0);
      rvalid1_q  <= issue & ~own_we & (state == OWN1);
    end
  end

  // Port-side outputs; reset masks grants and returns in the reset cycle.
  assign p0_gnt    = rst & (state == OWN0);
  assign p1_gnt    = rst & (state == OWN1);
  assign p0_rvalid = rst & rvalid0_q;
  assign p1_rvalid = rst & rvalid1_q;
  assign p0_rdata  = DMdouta;
  assign p1_rdata  = DMdouta;

  // Memory-side outputs; address and data are zero while IDLE.
  assign DMclka  = sysclk;
  assign DMena   = issue;
  assign DMwea   = issue & own_we;
  assign DMaddra = own_addr;
  assign DMdina  = own_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter with a behavioural memory,
// a read-return scoreboard and one task per scenario.
module tb_dm_arbiter;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [6:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        dm_clka, dm_ena, dm_wea;
  logic [6:0]  dm_addra;
  logic [31:0] dm_dina;
  logic [31:0] dm_douta = '0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  int          issue_log[$];
  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];

  dm_arbiter #(.MAX_BURST(8)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_gnt   (p0_gnt),
    .p0_rvalid(p0_rvalid),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_gnt   (p1_gnt),
    .p1_rvalid(p1_rvalid),
    .p1_rdata (p1_rdata),
    .DMclka   (dm_clka),
    .DMena    (dm_ena),
    .DMwea    (dm_wea),
    .DMaddra  (dm_addra),
    .DMdina   (dm_dina),
    .DMdouta  (dm_douta)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Single-port synchronous RAM model.
  always @(posedge dm_clka) begin
    if (dm_ena) begin
      if (dm_wea) mem[dm_addra] <= dm_dina;
      else        dm_douta      <= mem[dm_addra];
    end
  end

  // Read-return scoreboard: expected returns carry the cycle they are due in.
  always @(negedge sysclk) begin
    rd_exp_t e;
    checks++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.port == 0) begin
        if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0 || p0_rdata !== e.data) begin
          errors++;
          $display("FAIL rdata_p0 cyc=%0d: rvalid0=%b rvalid1=%b rdata=%h, want 1 0 %h",
                   cyc, p0_rvalid, p1_rvalid, p0_rdata, e.data);
        end
      end else begin
        if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0 || p1_rdata !== e.data) begin
          errors++;
          $display("FAIL rdata_p1 cyc=%0d: rvalid1=%b rvalid0=%b rdata=%h, want 1 0 %h",
                   cyc, p1_rvalid, p0_rvalid, p1_rdata, e.data);
        end
      end
    end else if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_rvalid cyc=%0d: rvalid0=%b rvalid1=%b, want 0 0",
               cyc, p0_rvalid, p1_rvalid);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive_port(input int port, input logic req, input logic we,
                            input logic [6:0] addr, input logic [31:0] data);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = data;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = data;
    end
  endtask

  task automatic push_read(input int port, input logic [6:0] addr);
    exp_q.push_back('{due: cyc + 1, port: port, data: ref_mem[addr]});
  endtask

  // One requester transaction: raise the request, wait (bounded) for the
  // grant, check the memory-side signals on the issue cycle, then return just
  // after the issuing edge with the request still high.
  task automatic port_access(input int port, input logic we, input logic [6:0] addr,
                             input logic [31:0] data, output int issue_cyc);
    bit done = 1'b0;
    issue_cyc = -1;
    drive_port(port, 1'b1, we, addr, data);
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge sysclk);
      if (((port == 0) ? p0_gnt : p1_gnt) === 1'b1) begin
        done      = 1'b1;
        issue_cyc = cyc;
        issue_log.push_back(port);
        checks++;
        if (dm_ena !== 1'b1 || dm_wea !== we || dm_addra !== addr ||
            (we && dm_dina !== data)) begin
          errors++;
          $display("FAIL issue_p%0d cyc=%0d: ena=%b wea=%b addr=%h din=%h, want 1 %b %h %h",
                   port, cyc, dm_ena, dm_wea, dm_addra, dm_dina, we, addr, data);
        end
        if (we) ref_mem[addr] = data;
        else    push_read(port, addr);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout_p%0d: no grant within 64 cycles, want grant", port);
    end
    step();
  endtask

  task automatic do_reset(input int n);
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  // Requests held high through reset must see no grant and no memory access.
  task automatic test_reset();
    drive_port(0, 1'b1, 1'b0, 7'h05, '0);
    drive_port(1, 1'b1, 1'b1, 7'h09, 32'h1234_5678);
    rst = 1'b0;
    repeat (3) begin
      @(negedge sysclk);
      checks++;
      if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || dm_ena !== 1'b0 || dm_wea !== 1'b0 ||
          p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b%b ena=%b wea=%b rvalid=%b%b, want all 0",
                 p0_gnt, p1_gnt, dm_ena, dm_wea, p0_rvalid, p1_rvalid);
      end
      step();
    end
  endtask

  // First read after reset: grant in cycle 1, issue in cycle 1, data in cycle 2.
  task automatic test_single_read();
    drive_port(1, 1'b0, 1'b0, '0, '0);
    drive_port(0, 1'b1, 1'b0, 7'h05, '0);
    rst = 1'b1;
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b0 || dm_ena !== 1'b0 || dm_addra !== 7'h00) begin
      errors++;
      $display("FAIL single_read_c0: gnt0=%b ena=%b addr=%h, want 0 0 00", p0_gnt, dm_ena, dm_addra);
    end
    step();
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || dm_ena !== 1'b1 || dm_wea !== 1'b0 ||
        dm_addra !== 7'h05) begin
      errors++;
      $display("FAIL single_read_c1: gnt=%b%b ena=%b wea=%b addr=%h, want 10 1 0 05",
               p0_gnt, p1_gnt, dm_ena, dm_wea, dm_addra);
    end
    push_read(0, 7'h05);
    step();
    drive_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge sysclk);
    checks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_read_c2: rvalid0=%b rdata=%h, want 1 deadbeef", p0_rvalid, p0_rdata);
    end
    step();
    drain(2);
  endtask

  // Port 1 alone streams 20 writes then a read-back with no gaps.
  task automatic test_p1_writes();
    int ic, prev;
    prev = -1;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) port_access(1, 1'b1, 7'(i), 32'(i), ic);
      else        port_access(1, 1'b0, 7'd19, '0, ic);
      if (i > 0) begin
        checks++;
        if (ic !== prev + 1) begin
          errors++;
          $display("FAIL p1_stream_gap access=%0d: issue cycle %0d, want %0d", i, ic, prev + 1);
        end
      end
      prev = ic;
    end
    drive_port(1, 1'b0, 1'b0, '0, '0);
    @(negedge sysclk);
    checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h0000_0013) begin
      errors++;
      $display("FAIL p1_readback: rvalid1=%b rdata=%h, want 1 00000013", p1_rvalid, p1_rdata);
    end
    step();
    drain(2);
  endtask

  // Tie-break from reset, release handover, and second tie after port 1 owned.
  task automatic test_tie();
    do_reset(2);
    drive_port(0, 1'b1, 1'b0, 7'd10, '0);
    drive_port(1, 1'b1, 1'b0, 7'd11, '0);
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie_idle: gnt=%b%b, want 00", p0_gnt, p1_gnt);
    end
    step();
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || dm_ena !== 1'b1) begin
      errors++;
      $display("FAIL tie_first: gnt=%b%b ena=%b, want 10 1", p0_gnt, p1_gnt, dm_ena);
    end
    push_read(0, 7'd10);
    step();
    drive_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge sysclk);
    checks++;
    if (dm_ena !== 1'b0) begin
      errors++;
      $display("FAIL release_dead_cycle: ena=%b, want 0", dm_ena);
    end
    step();
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1 || dm_ena !== 1'b1 || dm_addra !== 7'd11) begin
      errors++;
      $display("FAIL release_handover: gnt=%b%b ena=%b addr=%h, want 01 1 0b",
               p0_gnt, p1_gnt, dm_ena, dm_addra);
    end
    push_read(1, 7'd11);
    step();
    drive_port(1, 1'b0, 1'b0, '0, '0);
    step();
    drive_port(0, 1'b1, 1'b0, 7'd12, '0);
    drive_port(1, 1'b1, 1'b0, 7'd13, '0);
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie2_idle: gnt=%b%b, want 00", p0_gnt, p1_gnt);
    end
    step();
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL tie2_winner: gnt=%b%b, want 10", p0_gnt, p1_gnt);
    end
    push_read(0, 7'd12);
    step();
    drive_port(0, 1'b0, 1'b0, '0, '0);
    step();
    @(negedge sysclk);
    checks++;
    if (p1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL tie2_handover: gnt1=%b, want 1", p1_gnt);
    end
    push_read(1, 7'd13);
    step();
    drive_port(1, 1'b0, 1'b0, '0, '0);
    drain(3);
  endtask

  // Both ports request continuously: tenures of exactly 8 accesses alternate.
  task automatic test_fair_burst();
    do_reset(1);
    issue_log.delete();
    fork
      begin
        int ic;
        for (int i = 0; i < 24; i++) port_access(0, 1'b0, 7'(i), '0, ic);
        drive_port(0, 1'b0, 1'b0, '0, '0);
      end
      begin
        int ic;
        for (int i = 0; i < 24; i++) port_access(1, 1'b1, 7'(32 + i), $urandom, ic);
        drive_port(1, 1'b0, 1'b0, '0, '0);
      end
    join
    checks++;
    if (issue_log.size() != 48) begin
      errors++;
      $display("FAIL burst_count: %0d accesses, want 48", issue_log.size());
    end
    for (int i = 0; i < issue_log.size(); i++) begin
      checks++;
      if (issue_log[i] != (i / 8) % 2) begin
        errors++;
        $display("FAIL burst_order access=%0d: port %0d, want %0d", i, issue_log[i], (i / 8) % 2);
      end
    end
    drain(3);
  endtask

  // A read on the last cycle of a forced tenure returns to port 0 under p1_gnt.
  task automatic test_last_cycle_read();
    do_reset(1);
    fork
      begin
        int ic;
        for (int i = 0; i < 8; i++) port_access(0, 1'b0, (i == 7) ? 7'd3 : 7'(40 + i), '0, ic);
        drive_port(0, 1'b0, 1'b0, '0, '0);
        @(negedge sysclk);
        checks++;
        if (p1_gnt !== 1'b1 || p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0 ||
            p0_rdata !== ref_mem[3]) begin
          errors++;
          $display("FAIL last_cycle_read: gnt1=%b rvalid0=%b rvalid1=%b rdata=%h, want 1 1 0 %h",
                   p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, ref_mem[3]);
        end
      end
      begin
        int ic;
        port_access(1, 1'b0, 7'd50, '0, ic);
        drive_port(1, 1'b0, 1'b0, '0, '0);
      end
    join
    drain(3);
  endtask

  // Reset right after a port 1 read issue drops the pending return.
  task automatic test_reset_inflight();
    drive_port(1, 1'b1, 1'b0, 7'd7, '0);
    step();
    @(negedge sysclk);
    checks++;
    if (p1_gnt !== 1'b1 || dm_ena !== 1'b1) begin
      errors++;
      $display("FAIL inflight_issue: gnt1=%b ena=%b, want 1 1", p1_gnt, dm_ena);
    end
    step();
    rst = 1'b0;
    drive_port(1, 1'b0, 1'b0, '0, '0);
    @(negedge sysclk);
    checks++;
    if (p1_rvalid !== 1'b0 || dm_ena !== 1'b0) begin
      errors++;
      $display("FAIL inflight_reset_cycle: rvalid1=%b ena=%b, want 0 0", p1_rvalid, dm_ena);
    end
    step();
    rst = 1'b1;
    @(negedge sysclk);
    checks++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || dm_ena !== 1'b0 || p1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_after_reset: gnt=%b%b ena=%b rvalid1=%b, want 00 0 0",
               p0_gnt, p1_gnt, dm_ena, p1_rvalid);
    end
    drain(3);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    mem[5]     = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    test_reset();
    test_single_read();
    test_p1_writes();
    test_tie();
    test_fair_burst();
    test_last_cycle_read();
    test_reset_inflight();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
